dc_miss_handler: RTL and testbench
==================================

// Module: dc_miss_handler
// PURPOSE
//  Data-cache miss/refill controller, directly downstream of the dcache hit checker.
//  Consumes dc_miss/dc_evict, writes back the dirty victim line, then fetches the missing line
//  from the memory bus and writes it into the data and tag arrays.
//  Drives dc_miss_ack back to the hit checker; the checker suppresses hits while it is high.
//  Write-allocate: read and write misses are handled identically; the store merges on replay.
// PARAMETERS
//  TAG_W   6   physical tag width (matches tag store)
//  IDX_W   3   cache set index width
//  BEAT_W  2   log2 of bus beats per line; BEATS = 1<<BEAT_W
//  BUS_W   32  memory bus data width; line = BUS_W*BEATS bits
// PORTS
//  clk          in   1                  clock, all state updates on rising edge
//  rst_n        in   1                  reset, asynchronous, active-low
//  dc_miss      in   1                  miss detected this cycle (from hit checker)
//  dc_evict     in   1                  miss victim is valid and dirty
//  miss_idx     in   IDX_W              set index of the missing access
//  miss_tag     in   TAG_W              physical tag of the missing access
//  victim_tag   in   TAG_W              tag-store tag of the current occupant
//  victim_data  in   BUS_W*BEATS        data-array line of the current occupant; beat 0 in LSBs
//  dc_miss_ack  out  1                  registered; high in every state except IDLE
//  bus_req      out  1                  memory bus request, held high through a whole burst
//  bus_we       out  1                  1 = write-back beat, 0 = fill beat
//  bus_addr     out  TAG_W+IDX_W+BEAT_W word address {tag,idx,beat}
//  bus_wdata    out  BUS_W              write-back data for the current beat
//  bus_ack      in   1                  current beat completes this cycle
//  bus_rdata    in   BUS_W              fill data, valid when bus_ack && !bus_we
//  fill_wen     out  1                  one-cycle write strobe to data and tag arrays
//  fill_idx     out  IDX_W              set being written
//  fill_tag     out  TAG_W              new tag; the tag store sets valid=1 and dirty=0 on fill_wen
//  fill_data    out  BUS_W*BEATS        refilled line; beat 0 in LSBs
// BEHAVIOUR
//  States: IDLE, WB, FILL, UPDATE.
//  Reset (async, any state, mid-burst included): state=IDLE, beat=0, and to 0:
//   all outputs, captured idx/tags and the line buffers. A partial burst is abandoned.
//   The bus owner must tolerate bus_req dropping mid-burst.
//  IDLE: when dc_miss=1, capture miss_idx, miss_tag, victim_tag, victim_data and dc_evict.
//   Next state is WB if dc_evict=1, else FILL.
//   dc_miss_ack rises on the following cycle; it is low during the capture cycle.
//  WB: bus_req=1, bus_we=1, bus_addr={victim_tag,idx,beat}, bus_wdata=victim beat[beat].
//   Each bus_ack increments beat. An ack on beat BEATS-1 clears beat and moves to FILL.
//  FILL: bus_req=1, bus_we=0, bus_addr={miss_tag,idx,beat}.
//   On each bus_ack, store bus_rdata in line buffer slot [beat] and increment beat.
//   An ack on beat BEATS-1 moves to UPDATE.
//  bus_req, bus_we and bus_addr change only on ack edges. While bus_ack=0 they hold stable
//   (no timeout); wait states are unlimited.
//  UPDATE: fill_wen=1 for exactly one cycle with fill_idx, fill_tag=miss_tag and fill_data.
//   bus_req=0. Next state is IDLE.
//  dc_miss while not in IDLE is ignored (no queueing).
//   The requester replays after dc_miss_ack falls; the replay then hits.
//  bus_ack while bus_req=0 is ignored. beat wraps only through the explicit clear.
//  Latency with bus_ack tied high:
//   clean miss: dc_miss_ack high for BEATS+1 cycles.
//   dirty miss: dc_miss_ack high for 2*BEATS+1 cycles.
//  Back-to-back: a dc_miss in the IDLE cycle right after UPDATE starts a new miss.
// TESTING
//  1. Clean miss, idx=5, miss_tag=0x2A, ack tied 1 -> 4 fill beats at addrs {2A,5,0..3},
//     fill_wen on cycle 5, dc_miss_ack high cycles 1-5.
//  2. Dirty miss, victim_tag=0x11, victim_data=0x44..11 -> 4 writes with wdata
//     0x11..,0x22..,0x33..,0x44.., then 4 fills; dc_miss_ack high 9 cycles.
//  3. Random bus_ack stalls (0-5 cycles) during WB and FILL -> bus_addr and bus_wdata hold
//     during stalls; fill_data equals the 4 acked rdata words in order.
//  4. rst_n low for 1 cycle during FILL beat 2 -> all outputs 0 immediately;
//     no fill_wen; next miss starts at beat 0.
//  5. dc_miss pulsed during FILL -> ignored; exactly one fill_wen; capture regs unchanged.
//  6. Two misses back-to-back, the second in the first IDLE cycle after UPDATE ->
//     second miss captured; no bubble other than the IDLE capture cycle.

Source files
------------

// File: rtl/dc_miss_handler.sv
// Data-cache miss/refill controller: writes back a dirty victim line over the memory bus,
// fetches the missing line beat by beat, then writes it into the data and tag arrays.
//
// state  | meaning
// IDLE   | waiting for dc_miss; captures miss context on the request cycle
// WB     | writing victim line back, one beat per bus_ack
// FILL   | reading missing line, one beat per bus_ack, into the line buffer
// UPDATE | one-cycle fill_wen to data/tag arrays, then back to IDLE
module dc_miss_handler #(
  parameter int TAG_W  = 6,
  parameter int IDX_W  = 3,
  parameter int BEAT_W = 2,
  parameter int BUS_W  = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            dc_miss,
  input  logic                            dc_evict,
  input  logic [IDX_W-1:0]                miss_idx,
  input  logic [TAG_W-1:0]                miss_tag,
  input  logic [TAG_W-1:0]                victim_tag,
  input  logic [BUS_W*(1<<BEAT_W)-1:0]    victim_data,
  output logic                            dc_miss_ack,
  output logic                            bus_req,
  output logic                            bus_we,
  output logic [TAG_W+IDX_W+BEAT_W-1:0]   bus_addr,
  output logic [BUS_W-1:0]                bus_wdata,
  input  logic                            bus_ack,
  input  logic [BUS_W-1:0]                bus_rdata,
  output logic                            fill_wen,
  output logic [IDX_W-1:0]                fill_idx,
  output logic [TAG_W-1:0]                fill_tag,
  output logic [BUS_W*(1<<BEAT_W)-1:0]    fill_data
);

  localparam int BEATS  = 1 << BEAT_W;
  localparam int LINE_W = BUS_W * BEATS;

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
  localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WB     = 2'd1;
  localparam logic [1:0] S_FILL   = 2'd2;
  localparam logic [1:0] S_UPDATE = 2'd3;

  logic [1:0]        state_q,   state_d;
  logic [BEAT_W-1:0] beat_q,    beat_d;
  logic [IDX_W-1:0]  idx_q,     idx_d;
  logic [TAG_W-1:0]  mtag_q,    mtag_d;
  logic [TAG_W-1:0]  vtag_q,    vtag_d;
  logic [LINE_W-1:0] vdata_q,   vdata_d;
  logic [LINE_W-1:0] linebuf_q, linebuf_d;
  logic              ack_q,     ack_d;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    idx_d     = idx_q;
    mtag_d    = mtag_q;
    vtag_d    = vtag_q;
    vdata_d   = vdata_q;
    linebuf_d = linebuf_q;

    case (state_q)
      S_IDLE: begin
        if (dc_miss) begin
          idx_d   = miss_idx;
          mtag_d  = miss_tag;
          vtag_d  = victim_tag;
          vdata_d = victim_data;
          beat_d  = '0;
          state_d = dc_evict ? S_WB : S_FILL;
        end
      end
      S_WB: begin
        if (bus_ack) begin
          if (beat_q == BEAT_LAST) begin
            beat_d  = '0;
            state_d = S_FILL;
          end else begin
            beat_d = beat_q + BEAT_ONE;
          end
        end
      end
      S_FILL: begin
        if (bus_ack) begin
          linebuf_d[int'(beat_q)*BUS_W +: BUS_W] = bus_rdata;
          if (beat_q == BEAT_LAST) begin
            beat_d  = '0;
            state_d = S_UPDATE;
          end else begin
            beat_d = beat_q + BEAT_ONE;
          end
        end
      end
      S_UPDATE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Ack tracks the next state so it rises the cycle after capture and falls with IDLE.
    ack_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      idx_q     <= '0;
      mtag_q    <= '0;
      vtag_q    <= '0;
      vdata_q   <= '0;
      linebuf_q <= '0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      idx_q     <= idx_d;
      mtag_q    <= mtag_d;
      vtag_q    <= vtag_d;
      vdata_q   <= vdata_d;
      linebuf_q <= linebuf_d;
      ack_q     <= ack_d;
    end
  end

  // Bus outputs decode only registered state, so they move solely on ack edges.
  always_comb begin
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    case (state_q)
      S_WB: begin
        bus_req   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = {vtag_q, idx_q, beat_q};
        bus_wdata = vdata_q[int'(beat_q)*BUS_W +: BUS_W];
      end
      S_FILL: begin
        bus_req  = 1'b1;
        bus_addr = {mtag_q, idx_q, beat_q};
      end
      default: ;
    endcase
  end

  assign dc_miss_ack = ack_q;
  assign fill_wen    = (state_q == S_UPDATE);
  assign fill_idx    = idx_q;
  assign fill_tag    = mtag_q;
  assign fill_data   = linebuf_q;

endmodule

// File: tb/tb_dc_miss_handler.sv
// Testbench for dc_miss_handler: a randomized bus slave checks each miss against an expected
// transaction list built from the miss context (write-back beats, fill beats, one fill).
module tb_dc_miss_handler;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         dc_miss, dc_evict;
  logic [2:0]   miss_idx;
  logic [5:0]   miss_tag, victim_tag;
  logic [127:0] victim_data;
  logic         dc_miss_ack, bus_req, bus_we;
  logic [10:0]  bus_addr;
  logic [31:0]  bus_wdata;
  logic         bus_ack;
  logic [31:0]  bus_rdata;
  logic         fill_wen;
  logic [2:0]   fill_idx;
  logic [5:0]   fill_tag;
  logic [127:0] fill_data;

  int n_tests = 0;
  int n_fail  = 0;

  dc_miss_handler dut (
    .clk(clk), .rst_n(rst_n), .dc_miss(dc_miss), .dc_evict(dc_evict),
    .miss_idx(miss_idx), .miss_tag(miss_tag), .victim_tag(victim_tag),
    .victim_data(victim_data), .dc_miss_ack(dc_miss_ack), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .fill_wen(fill_wen), .fill_idx(fill_idx),
    .fill_tag(fill_tag), .fill_data(fill_data)
  );

  always #5 clk = ~clk;

  // Called at a negedge with the DUT in IDLE; returns at the first negedge with ack low again.
  task automatic run_miss(input logic [2:0] idx, input logic [5:0] mtag, input logic [5:0] vtag,
                          input logic [127:0] vdata, input logic evict, input int max_stall,
                          input int pulse_at, input string name,
                          output int ack_cycles, output int fill_cycle);
    logic [10:0]  ea[$];
    logic         ew[$];
    logic [31:0]  ed[$];
    logic [127:0] line;
    int n, stall, req_cycles, fills, b, nwb;
    bit done;
    line = '0;
    nwb  = evict ? 4 : 0;
    for (int i = 0; i < 4; i++) begin
      if (evict) begin
        ea.push_back({vtag, idx, 2'(i)}); ew.push_back(1'b1); ed.push_back(vdata[32*i +: 32]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      ea.push_back({mtag, idx, 2'(i)}); ew.push_back(1'b0); ed.push_back(32'h0);
    end

    n_tests++;
    if (dc_miss_ack !== 1'b0) begin
      n_fail++; $display("FAIL %s ack_in_capture_cycle: got %b need 0", name, dc_miss_ack);
    end
    dc_miss = 1'b1; miss_idx = idx; miss_tag = mtag; victim_tag = vtag;
    victim_data = vdata; dc_evict = evict;
    bus_ack = 1'($urandom_range(0, 1)); bus_rdata = $urandom;

    n = 0; stall = $urandom_range(0, max_stall); ack_cycles = 0; req_cycles = 0;
    fills = 0; fill_cycle = 0; done = 0;
    for (int k = 1; k <= 300 && !done; k++) begin
      @(negedge clk);
      if (k == pulse_at) begin
        dc_miss = 1'b1; miss_idx = 3'($urandom); miss_tag = 6'($urandom);
        victim_tag = 6'($urandom); victim_data = {$urandom, $urandom, $urandom, $urandom};
        dc_evict = 1'($urandom);
      end else begin
        dc_miss = 1'b0;
      end
      if (k == 1) begin
        n_tests++;
        if (dc_miss_ack !== 1'b1) begin
          n_fail++; $display("FAIL %s ack_rise: got %b need 1", name, dc_miss_ack);
        end
      end
      if (dc_miss_ack !== 1'b1) begin
        done = 1; bus_ack = 1'b0;
      end else begin
        ack_cycles++;
        if (fill_wen === 1'b1) begin
          fills++; fill_cycle = ack_cycles; n_tests++;
          if ({fill_idx, fill_tag, fill_data} !== {idx, mtag, line}) begin
            n_fail++;
            $display("FAIL %s fill: got idx=%h tag=%h data=%h need idx=%h tag=%h data=%h",
                     name, fill_idx, fill_tag, fill_data, idx, mtag, line);
          end
        end
        if (bus_req === 1'b1) begin
          req_cycles++; n_tests++;
          if (n >= ea.size()) begin
            n_fail++; $display("FAIL %s extra_beat: got addr=%h need no request", name, bus_addr);
          end else if (bus_addr !== ea[n] || bus_we !== ew[n] || (ew[n] && bus_wdata !== ed[n])) begin
            n_fail++;
            $display("FAIL %s beat%0d: got addr=%h we=%b wdata=%h need addr=%h we=%b wdata=%h",
                     name, n, bus_addr, bus_we, bus_wdata, ea[n], ew[n], ed[n]);
          end
          if (stall > 0) begin
            bus_ack = 1'b0; stall--;
          end else begin
            bus_ack = 1'b1; bus_rdata = $urandom;
            if (n >= nwb && n < ea.size()) begin
              b = n - nwb;
              line[32*b +: 32] = bus_rdata;
            end
            n++;
            stall = $urandom_range(0, max_stall);
          end
        end else begin
          bus_ack = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
        end
      end
    end
    dc_miss = 1'b0;

    n_tests++;
    if (!done) begin
      n_fail++; $display("FAIL %s timeout: ack still high after 300 cycles, need low", name);
    end
    n_tests++;
    if (n != ea.size()) begin
      n_fail++; $display("FAIL %s beat_count: got %0d need %0d", name, n, ea.size());
    end
    n_tests++;
    if (fills != 1) begin
      n_fail++; $display("FAIL %s fill_count: got %0d need 1", name, fills);
    end
    n_tests++;
    if (ack_cycles != req_cycles + 1 || fill_cycle != ack_cycles) begin
      n_fail++;
      $display("FAIL %s ack_span: got ack=%0d fill_at=%0d need ack=%0d fill_at=%0d",
               name, ack_cycles, fill_cycle, req_cycles + 1, req_cycles + 1);
    end
  endtask

  task automatic check_all_zero(input string name);
    n_tests++;
    if ({dc_miss_ack, bus_req, bus_we, bus_addr, bus_wdata, fill_wen, fill_idx, fill_tag,
         fill_data} !== '0) begin
      n_fail++;
      $display("FAIL %s outputs: got ack=%b req=%b we=%b addr=%h wdata=%h wen=%b idx=%h tag=%h data=%h need all 0",
               name, dc_miss_ack, bus_req, bus_we, bus_addr, bus_wdata, fill_wen, fill_idx,
               fill_tag, fill_data);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; dc_miss = 1'b0; dc_evict = 1'b0; miss_idx = '0; miss_tag = '0;
    victim_tag = '0; victim_data = '0; bus_ack = 1'b0; bus_rdata = '0;
    #1 check_all_zero("reset");
    repeat (2) @(negedge clk);
    check_all_zero("reset_held");
    rst_n = 1'b1;
  endtask

  task automatic test_clean_miss();
    int ac, fc;
    @(negedge clk);
    run_miss(3'd5, 6'h2A, 6'($urandom), {$urandom, $urandom, $urandom, $urandom}, 1'b0, 0, -1,
             "clean", ac, fc);
    n_tests++;
    if (ac != 5 || fc != 5) begin
      n_fail++; $display("FAIL clean latency: got ack=%0d fill_at=%0d need 5 and 5", ac, fc);
    end
  endtask

  task automatic test_dirty_miss();
    int ac, fc;
    @(negedge clk);
    run_miss(3'($urandom), 6'($urandom), 6'h11,
             128'h44444444_33333333_22222222_11111111, 1'b1, 0, -1, "dirty", ac, fc);
    n_tests++;
    if (ac != 9 || fc != 9) begin
      n_fail++; $display("FAIL dirty latency: got ack=%0d fill_at=%0d need 9 and 9", ac, fc);
    end
  endtask

  task automatic test_stalls();
    int ac, fc;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      run_miss(3'($urandom), 6'($urandom), 6'($urandom),
               {$urandom, $urandom, $urandom, $urandom}, 1'($urandom), 5, -1, "stall", ac, fc);
    end
  endtask

  task automatic test_reset_midburst();
    int ac, fc;
    bit bad;
    @(negedge clk);
    dc_miss = 1'b1; miss_idx = 3'd3; miss_tag = 6'h15; dc_evict = 1'b0; bus_ack = 1'b1;
    @(negedge clk);
    dc_miss = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (bus_addr !== {6'h15, 3'd3, 2'd2} || bus_req !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid pre_reset: got req=%b addr=%h need 1 %h",
                         bus_req, bus_addr, {6'h15, 3'd3, 2'd2});
    end
    rst_n = 1'b0; bus_ack = 1'b0;
    #1 check_all_zero("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (fill_wen !== 1'b0 || dc_miss_ack !== 1'b0 || bus_req !== 1'b0) bad = 1;
    end
    n_tests++;
    if (bad) begin
      n_fail++; $display("FAIL rst_mid idle_after: got activity need none");
    end
    run_miss(3'($urandom), 6'($urandom), 6'($urandom),
             {$urandom, $urandom, $urandom, $urandom}, 1'b1, 2, -1, "after_rst", ac, fc);
  endtask

  task automatic test_miss_during_fill();
    int ac, fc;
    @(negedge clk);
    run_miss(3'd6, 6'h3C, 6'h07, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 0, 2,
             "pulse_fill", ac, fc);
    n_tests++;
    if (ac != 5) begin
      n_fail++; $display("FAIL pulse_fill latency: got %0d need 5", ac);
    end
  endtask

  task automatic test_back_to_back();
    int ac, fc;
    @(negedge clk);
    run_miss(3'd1, 6'h22, 6'h33, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 0, -1,
             "b2b_first", ac, fc);
    run_miss(3'd2, 6'h0F, 6'h30, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 0, -1,
             "b2b_second", ac, fc);
    n_tests++;
    if (ac != 5) begin
      n_fail++; $display("FAIL b2b_second latency: got %0d need 5", ac);
    end
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_stalls();
    test_reset_midburst();
    test_miss_during_fill();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
